fft_result_reader: RTL

Unload engine that reads completed FFT results out of the shared real/imag result RAMs (W_RAM/I_RAM) after the butterfly passes finish. It issues RAM reads itself, optionally in bit-reversed address order, and streams natural-order bins out on a valid/ready interface. A credit-limited skid FIFO absorbs the RAM read latency and downstream backpressure. It is the read-side counterpart of the butterfly block's RAM write-back.

---
 rtl/fft_result_reader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fft_result_reader.sv
// Unload engine: reads completed FFT results from the real/imag result RAMs,
// optionally bit-reversed, and streams natural-order bins on valid/ready.
module fft_result_reader #(
  parameter int SIZE       = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int BITREV     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_re_dout,
  input  logic [DATA_W-1:0] ram_im_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] LAST_K  = (ADDR_W + 1)'(SIZE - 1);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] bitrev_f(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W:0]     k_iss_q, k_iss_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   infl_tag_q, infl_tag_d;
  logic                infl_last_q, infl_last_d;
  logic [CW-1:0]       count_q, count_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   re_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   re_d [FIFO_DEPTH];
  logic [DATA_W-1:0]   im_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   im_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]   tag_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   tag_d [FIFO_DEPTH];
  logic                last_q [FIFO_DEPTH];
  logic                last_d [FIFO_DEPTH];
  logic                pop_s, push_s;
  logic [CW-1:0]       wr_idx_s;
  logic [CW:0]         occ_s;

  // Shift FIFO: slot 0 is always the head, so outputs come straight from flops.
  always_comb begin
    pop_s    = valid_q & out_ready;
    push_s   = inflight_q;
    wr_idx_s = count_q - {{(CW-1){1'b0}}, pop_s};
    count_d  = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    valid_d  = (count_d != {CW{1'b0}});
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push_s && (wr_idx_s == CW'(i))) begin
        re_d[i]   = ram_re_dout;
        im_d[i]   = ram_im_dout;
        tag_d[i]  = infl_tag_q;
        last_d[i] = infl_last_q;
      end else if (pop_s) begin
        re_d[i]   = re_q[(i < FIFO_DEPTH - 1) ? i + 1 : i];
        im_d[i]   = im_q[(i < FIFO_DEPTH - 1) ? i + 1 : i];
        tag_d[i]  = tag_q[(i < FIFO_DEPTH - 1) ? i + 1 : i];
        last_d[i] = last_q[(i < FIFO_DEPTH - 1) ? i + 1 : i];
      end else begin
        re_d[i]   = re_q[i];
        im_d[i]   = im_q[i];
        tag_d[i]  = tag_q[i];
        last_d[i] = last_q[i];
      end
    end
  end

  // Sequencer: read issue under the occupancy credit, and run completion.
  always_comb begin
    state_d     = state_q;
    k_iss_d     = k_iss_q;
    ram_addr_d  = ram_addr_q;
    inflight_d  = 1'b0;
    infl_tag_d  = infl_tag_q;
    infl_last_d = infl_last_q;
    occ_s       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_iss_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (occ_s < DEPTH_C) begin
          ram_addr_d  = (BITREV != 0) ? bitrev_f(k_iss_q[ADDR_W-1:0]) : k_iss_q[ADDR_W-1:0];
          inflight_d  = 1'b1;
          infl_tag_d  = k_iss_q[ADDR_W-1:0];
          infl_last_d = (k_iss_q == LAST_K);
          k_iss_d     = k_iss_q + {{ADDR_W{1'b0}}, 1'b1};
          state_d     = (k_iss_q == LAST_K) ? S_DRAIN : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // Leaving on the final handshake edge puts done in the very next cycle.
        if (!inflight_q && (count_d == {CW{1'b0}})) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State, credit tracking and FIFO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_iss_q     <= '0;
      ram_addr_q  <= '0;
      inflight_q  <= 1'b0;
      infl_tag_q  <= '0;
      infl_last_q <= 1'b0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        re_q[i]   <= '0;
        im_q[i]   <= '0;
        tag_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      k_iss_q     <= k_iss_d;
      ram_addr_q  <= ram_addr_d;
      inflight_q  <= inflight_d;
      infl_tag_q  <= infl_tag_d;
      infl_last_q <= infl_last_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        re_q[i]   <= re_d[i];
        im_q[i]   <= im_d[i];
        tag_q[i]  <= tag_d[i];
        last_q[i] <= last_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = ram_addr_q;
  assign out_valid = valid_q;
  assign out_re    = re_q[0];
  assign out_im    = im_q[0];
  assign out_index = tag_q[0];
  assign out_last  = last_q[0];

endmodule
